rr_chan_seq: RTL

RR_CHAN_SEQ -- requirements
Module: rr_chan_seq

---
 rtl/rr_chan_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/rr_chan_seq.sv
// Round-robin channel sequencer: grants one of 8 requesters, drives a mux8 select, and captures
// the settled mux output into a valid/ready output register. Optional macro: RR_CHAN_MASK_EN.
module rr_chan_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
`ifdef RR_CHAN_MASK_EN
  input  logic [7:0]       chan_mask,
`endif
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic [7:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e           r_state;
  logic [2:0]       r_sel;
  logic [2:0]       r_last;
  logic [7:0]       r_ack;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_out_chan;
  logic             r_out_valid;

  logic [7:0]       w_elig;
  logic [2:0]       w_idx;
  logic [2:0]       w_winner;
  logic             w_found;

`ifdef RR_CHAN_MASK_EN
  assign w_elig = req & ~chan_mask;
`else
  assign w_elig = req;
`endif

  // Scan offsets 8..1 so the lowest offset after r_last overwrites and wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      w_idx = r_last + 3'(i);
      if (w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= 3'd0;
      r_last      <= 3'd7;
      r_ack       <= 8'd0;
      r_out_data  <= '0;
      r_out_chan  <= 3'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_ack <= 8'd0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_sel   <= w_winner;
            r_state <= StGrant;
          end
        end
        // Mux has had a full cycle to settle on r_sel; capture regardless of req/mask now.
        StGrant: begin
          r_out_data  <= mux_data;
          r_out_chan  <= r_sel;
          r_out_valid <= 1'b1;
          r_ack       <= 8'd1 << r_sel;
          r_last      <= r_sel;
          r_state     <= StHold;
        end
        StHold: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sel       = r_sel;
  assign ack       = r_ack;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
